// File: rtl/store_buffer_pkg.sv
// rtl/store_buffer_pkg.sv - shared types, funct3 codes and access helpers for the store buffer
package store_buffer_pkg;

    // Entry layout widths; the top-level DM_ADDRESS / DATA_W defaults track these.
    localparam int SB_ADDR_W = 9;
    localparam int SB_DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
        logic [2:0]           funct3;
    } sb_entry_t;

    // Bytes touched by an access; the low two funct3 bits carry the size for loads and stores alike.
    function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   access_bytes = 3'd1;
            2'b01:   access_bytes = 3'd2;
            default: access_bytes = 3'd4;
        endcase
    endfunction

    // Stores other than SB/SH behave as SW, so the buffered entry carries SW for them.
    function automatic logic [2:0] normalize_store_f3(input logic [2:0] funct3);
        case (funct3)
            F3_B:    normalize_store_f3 = F3_B;
            F3_H:    normalize_store_f3 = F3_H;
            default: normalize_store_f3 = F3_W;
        endcase
    endfunction

    // Truncate forwarded store data to the load width and sign/zero-extend it.
    function automatic logic [SB_DATA_W-1:0] extend_load(input logic [SB_DATA_W-1:0] data,
                                                         input logic [2:0]           funct3);
        case (funct3)
            F3_B:    extend_load = {{(SB_DATA_W-8){data[7]}}, data[7:0]};
            F3_H:    extend_load = {{(SB_DATA_W-16){data[15]}}, data[15:0]};
            F3_BU:   extend_load = {{(SB_DATA_W-8){1'b0}}, data[7:0]};
            F3_HU:   extend_load = {{(SB_DATA_W-16){1'b0}}, data[15:0]};
            default: extend_load = data;
        endcase
    endfunction

endpackage

// File: rtl/sb_forward.sv
// rtl/sb_forward.sv - youngest-match RAW forwarding search over buffered stores
module sb_forward
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  sb_entry_t              entries_i [DEPTH],
    input  logic [PTR_W-1:0]       rd_ptr_i,
    input  logic [CNT_W-1:0]       count_i,
    input  logic                   ld_valid_i,
    input  logic [SB_ADDR_W-1:0]   ld_addr_i,
    input  logic [2:0]             ld_funct3_i,
    output logic                   ld_hit_o,
    output logic                   ld_stall_o,
    output logic [SB_DATA_W-1:0]   ld_data_o
);

    logic             found;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] hit_idx;
    sb_entry_t        youngest;
    logic [2:0]       st_bytes;
    logic [2:0]       ld_bytes;

    // Walk live entries oldest to youngest; a later match overrides, so the youngest wins.
    always_comb begin
        found   = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_i + PTR_W'(k);
            if ((CNT_W'(k) < count_i) && (entries_i[idx].addr == ld_addr_i)) begin
                found   = 1'b1;
                hit_idx = idx;
            end
        end
    end

    // A wide-enough store forwards; a narrower one forces the load to wait for memory.
    always_comb begin
        youngest   = entries_i[hit_idx];
        st_bytes   = access_bytes(youngest.funct3);
        ld_bytes   = access_bytes(ld_funct3_i);
        ld_hit_o   = ld_valid_i && found && (st_bytes >= ld_bytes);
        ld_stall_o = ld_valid_i && found && (st_bytes < ld_bytes);
        ld_data_o  = ld_hit_o ? extend_load(youngest.data, ld_funct3_i) : '0;
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - pending-store FIFO between EX/MEM and datamemory with load forwarding
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter  int DEPTH      = 4,
    parameter  int DM_ADDRESS = SB_ADDR_W,
    parameter  int DATA_W     = SB_DATA_W,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  st_valid,
    input  logic [DM_ADDRESS-1:0] st_addr,
    input  logic [DATA_W-1:0]     st_data,
    input  logic [2:0]            st_funct3,
    output logic                  st_ready,
    input  logic                  ld_valid,
    input  logic [DM_ADDRESS-1:0] ld_addr,
    input  logic [2:0]            ld_funct3,
    output logic                  ld_hit,
    output logic [DATA_W-1:0]     ld_data,
    output logic                  ld_stall,
    input  logic                  drain,
    output logic                  dm_MemWrite,
    output logic [DM_ADDRESS-1:0] dm_a,
    output logic [DATA_W-1:0]     dm_wd,
    output logic [2:0]            dm_Funct3,
    output logic                  empty,
    output logic [CNT_W-1:0]      count
);

    sb_entry_t        entries_q [DEPTH];
    sb_entry_t        st_entry;
    sb_entry_t        head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;
    logic             fwd_stall;

    assign empty    = (count_q == '0);
    assign st_ready = (count_q != CNT_W'(DEPTH));
    assign count    = count_q;
    assign push     = st_valid && st_ready;
    // The port is free unless a load wants it; a stalled load yields it so its blocker can drain.
    assign pop      = !empty && (drain || !ld_valid || fwd_stall);
    assign ld_stall = fwd_stall;

    assign st_entry.addr   = st_addr;
    assign st_entry.data   = st_data;
    assign st_entry.funct3 = normalize_store_f3(st_funct3);

    // Next-state pointers and occupancy; simultaneous push and pop leaves count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards every pending store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: only slots inside [rd_ptr, rd_ptr+count) are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            entries_q[wr_ptr_q] <= st_entry;
        end
    end

    assign head        = entries_q[rd_ptr_q];
    assign dm_MemWrite = pop;
    assign dm_a        = empty ? '0 : head.addr;
    assign dm_wd       = empty ? '0 : head.data;
    assign dm_Funct3   = empty ? '0 : head.funct3;

    sb_forward #(
        .DEPTH (DEPTH)
    ) u_forward (
        .entries_i   (entries_q),
        .rd_ptr_i    (rd_ptr_q),
        .count_i     (count_q),
        .ld_valid_i  (ld_valid),
        .ld_addr_i   (ld_addr),
        .ld_funct3_i (ld_funct3),
        .ld_hit_o    (ld_hit),
        .ld_stall_o  (fwd_stall),
        .ld_data_o   (ld_data)
    );

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- DEPTH-entry FIFO of pending stores between the EX/MEM pipeline register and the datamemory block. Upstream sees a write as complete at enqueue.
- Entries drain to datamemory one per cycle, only when the shared memory port is not taken by a load or when a drain is forced.
- Loads in MEM are checked against buffered stores and either forwarded (RAW bypass) or stalled until the conflicting entry drains.

Parameters:
- DEPTH, 4: buffer entries; power of two, >=2.
- DM_ADDRESS, 9: address width, matching datamemory.
- DATA_W, 32: data width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- st_valid  in  1  store present in MEM stage
- st_addr  in  DM_ADDRESS  store address
- st_data  in  DATA_W  store data, unaligned-in-lane as datamemory expects
- st_funct3  in  3  000 SB, 001 SH, 010 SW; others treated as SW
- st_ready  out  1  buffer can accept a store (not full)
- ld_valid  in  1  load present in MEM stage
- ld_addr  in  DM_ADDRESS  load address
- ld_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ld_hit  out  1  ld_data valid, forwarded from buffer
- ld_data  out  DATA_W  forwarded, sign/zero-extended per ld_funct3
- ld_stall  out  1  partial-overlap conflict; hold pipeline
- drain  in  1  fence: pop every cycle regardless of ld_valid
- dm_MemWrite  out  1  write strobe to datamemory
- dm_a  out  DM_ADDRESS  head entry address
- dm_wd  out  DATA_W  head entry data
- dm_Funct3  out  3  head entry funct3
- empty  out  1  no pending entries
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async assert, sync-safe deassert): wr_ptr=rd_ptr=count=0. Outputs: empty=1, st_ready=1, dm_MemWrite=0, ld_hit=0, ld_stall=0, ld_data=0, dm_a/dm_wd/dm_Funct3=0. Entry contents are don't-care.
- Push: st_valid && st_ready at the clock edge writes {addr,data,funct3} at wr_ptr, then wr_ptr++. Stores are accepted with zero latency.
- st_ready = (count != DEPTH). A store offered while full is not taken; upstream holds it (stalls) until accepted.
- Pop: pop = !empty && (drain || !ld_valid || ld_stall). This is combinational.
- dm_MemWrite = pop. dm_a/dm_wd/dm_Funct3 are driven from the head entry whenever !empty, else 0.
- The datamemory write occurs during the pop cycle. rd_ptr++ at the edge.
- During ld_stall the buffer owns the port; the pipeline must suppress MemRead for the stalled load.
- Push and pop in the same cycle: count unchanged; both pointers advance. Pointers wrap modulo DEPTH.
- Forwarding (combinational, existing entries only; the same-cycle incoming store is not compared):
  - match_i = valid_i && addr_i == ld_addr. Select the youngest matching entry.
  - Widths: store 1/2/4 bytes; load 1 (LB/LBU), 2 (LH/LHU), 4 (LW).
  - Youngest match exists and store width >= load width: ld_hit=1. ld_data = entry data truncated to load width, sign-extended for LB/LH, zero-extended for LBU/LHU, full word for LW.
  - Youngest match exists and store width < load width: ld_hit=0, ld_stall=1. Stall persists until that entry drains; the load then reads memory.
  - No match or ld_valid=0: ld_hit=0, ld_stall=0, ld_data=0.
- drain=1 pops one entry per cycle until empty. It has no effect when empty; empty deasserts nothing.
- Reset mid-operation discards all pending stores, and no dm_MemWrite pulse follows. This is accepted behaviour; a fence before reset is software's job.
- count changes: +1 on push-only, -1 on pop-only. It never exceeds DEPTH and never underflows.

Decomposition:
- Package store_buffer_pkg:
  - funct3 localparams (F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101)
  - typedef sb_entry_t {addr, data, funct3}
  - function access_bytes(funct3) -> 1/2/4
  - function extend_load(data, funct3)
- One sub-module: sb_forward. Purely combinational youngest-match priority search over the entry array plus rd_ptr/count; produces ld_hit, ld_stall, ld_data.
- The FIFO, pointers and port logic stay in store_buffer.

Test Plan:
- Reset then SW addr 0x010 data 0xDEADBEEF, ld_valid=0 -> next cycle dm_MemWrite=1, dm_a=0x010, dm_wd=0xDEADBEEF, dm_Funct3=010; count 1->0; empty=1.
- 4 SW pushes with ld_valid=1 held -> count=4, st_ready=0. A 5th store is not accepted. Drop ld_valid -> 4 consecutive pops in FIFO order.
- Buffered SW 0x12348086 @0x020, LB @0x020 -> ld_hit=1, ld_data=0xFFFFFF86. LBU -> 0x00000086. LH -> 0xFFFF8086.
- Two SW to 0x030 (0x1111, then 0x2222) both pending, LW @0x030 -> ld_hit=1, ld_data=0x00002222 (youngest wins).
- Buffered SB 0x7F @0x040, LW @0x040 -> ld_stall=1, dm_MemWrite=1 for the SB entry. Next cycle ld_stall=0, ld_hit=0.
- Three entries pending, drain=1 and ld_valid=1 -> 3 consecutive pops. Separately, assert reset mid-drain -> count=0, empty=1, dm_MemWrite=0 immediately (asynchronous).
